// File: rtl/store_buffer_if.sv
// Bundle of core store/load-forward signals and the memory drain handshake
// seen by the posted-write store buffer.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                     MemWrite;
  logic [AW-1:0]            DataAdr;
  logic [DW-1:0]            WriteData;
  logic                     Stall;
  logic [AW-1:0]            ReadAdr;
  logic                     ReadHit;
  logic [DW-1:0]            ReadFwdData;
  logic                     MemReq;
  logic [AW-1:0]            MemAdr;
  logic [DW-1:0]            MemWData;
  logic                     MemAck;
  logic                     Empty;
  logic [$clog2(DEPTH):0]   Count;

  modport master (
    output MemWrite, DataAdr, WriteData, ReadAdr, MemAck,
    input  Stall, ReadHit, ReadFwdData, MemReq, MemAdr, MemWData, Empty, Count
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, ReadAdr, MemAck,
    output Stall, ReadHit, ReadFwdData, MemReq, MemAdr, MemWData, Empty, Count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drain to memory, same-word merge
// into the youngest entry, and youngest-match load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  store_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full, empty;
  logic          accept, pop, coalesce, push;
  logic [PW-1:0] young_idx;
  logic [PW-1:0] fwd_idx;
  logic          hit;
  logic [DW-1:0] fwd_data;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign young_idx = tail_q - PW'(1);

  assign accept   = bus.MemWrite && !full;
  assign pop      = !empty && bus.MemAck;
  // Never merge into the head: it may already be mid-handshake with memory.
  assign coalesce = accept && (count_q >= CW'(2)) &&
                    (addr_q[young_idx][AW-1:2] == bus.DataAdr[AW-1:2]);
  assign push     = accept && !coalesce;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.DataAdr;
      data_q[tail_q] <= bus.WriteData;
    end
    if (coalesce) data_q[young_idx] <= bus.WriteData;
  end

  // Scan oldest to youngest so the last valid match (youngest) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (addr_q[fwd_idx][AW-1:2] == bus.ReadAdr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.ReadHit     = hit;
  assign bus.ReadFwdData = fwd_data;
  assign bus.Stall       = full;
  assign bus.Empty       = empty;
  assign bus.Count       = count_q;
  assign bus.MemReq      = !empty;
  assign bus.MemAdr      = empty ? '0 : addr_q[head_q];
  assign bus.MemWData    = empty ? '0 : data_q[head_q];
endmodule
